// File: rtl/mem_fetch_unit_if.sv
// Memory request port between the fetch unit and the memory system.
//   mem_req   : an access is outstanding (held until mem_ack)
//   mem_we    : outstanding access is a write
//   mem_addr  : byte address, stable while mem_req is high
//   mem_wdata : store data, stable while mem_req is high
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : completes the outstanding access
interface mem_fetch_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_fetch_unit.sv
// Multicycle-CPU memory fetch unit: owns PC, IR and MDR, turns controller
// strobes into single outstanding memory accesses and stalls the controller
// until each access completes (or a watchdog gives up on it).
//   clk, reset        : clock, async active-high reset
//   pcEn, IRwrite, memwrite, memread, IorD, pcsrc : controller strobes
//   aluresult, aluout, writedata : datapath sources for PC / address / store
//   mem               : memory request port (master side)
//   pc, instr, mdr    : architectural registers; op/funct decode of instr
//   stall             : hold controller state while high
//   err               : sticky watchdog timeout flag
module mem_fetch_unit (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pcEn,
  input  logic                    IRwrite,
  input  logic                    memwrite,
  input  logic                    memread,
  input  logic                    IorD,
  input  logic [1:0]              pcsrc,
  input  logic [31:0]             aluresult,
  input  logic [31:0]             aluout,
  input  logic [31:0]             writedata,
  mem_fetch_unit_if.master        mem,
  output logic [31:0]             pc,
  output logic [31:0]             instr,
  output logic [31:0]             mdr,
  output logic [5:0]              op,
  output logic [5:0]              funct,
  output logic                    stall,
  output logic                    err
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_WRITE = 2'd2;

  logic [0:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_kind;
  logic [7:0]  r_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_mdr;
  logic        r_err;

  logic        w_areq;
  logic [1:0]  w_kind;
  logic        w_busy;
  logic        w_ack;
  logic        w_tmo;
  logic [31:0] w_pc_next;

  assign w_areq = IRwrite | memread | memwrite;
  // Fetch wins over a simultaneous store.
  assign w_kind = IRwrite ? K_FETCH : (memwrite ? K_WRITE : K_READ);
  assign w_busy = (r_state == S_BUSY);
  // Ack only means something while an access is outstanding.
  assign w_ack  = w_busy & mem.mem_ack;
  // 255th BUSY cycle without ack: counter is about to reach 255, give up.
  assign w_tmo  = w_busy & ~mem.mem_ack & (r_cnt == 8'd254);

  // The timeout cycle releases the controller so it is not wedged forever.
  assign stall = (~w_busy & w_areq) | (w_busy & ~mem.mem_ack & ~w_tmo);

  assign mem.mem_req   = w_busy;
  assign mem.mem_we    = w_busy & (r_kind == K_WRITE);
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  always_comb begin
    w_pc_next = r_pc;
    case (pcsrc)
      2'b00:   w_pc_next = aluresult;
      2'b01:   w_pc_next = aluout;
      2'b10:   w_pc_next = {r_pc[31:28], r_instr[25:0], 2'b00};
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_kind  <= K_FETCH;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_instr <= '0;
      r_mdr   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (pcEn && !stall) r_pc <= w_pc_next;
      case (r_state)
        S_IDLE: begin
          if (w_areq) begin
            r_addr  <= IorD ? aluout : r_pc;
            r_wdata <= writedata;
            r_kind  <= w_kind;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        default: begin
          if (w_ack) begin
            if (r_kind == K_FETCH) r_instr <= mem.mem_rdata;
            if (r_kind == K_READ)  r_mdr   <= mem.mem_rdata;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_tmo) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign pc    = r_pc;
  assign instr = r_instr;
  assign mdr   = r_mdr;
  assign err   = r_err;
  assign op    = r_instr[31:26];
  assign funct = r_instr[5:0];
endmodule

// File: doc/mem_fetch_unit.md
MEM_FETCH_UNIT -- requirements
Module: mem_fetch_unit

Interface
REQ-001 The block SHALL have a single clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  async active-high reset.
REQ-004 pcEn, IRwrite, memwrite, memread, IorD  input  1 each  controller strobes for the current cycle.
REQ-005 pcsrc  input  2  next-PC select: 00 aluresult, 01 aluout, 10 jump target, 11 hold.
REQ-006 aluresult, aluout, writedata  input  32 each  ALU result, ALUOut register, B register.
REQ-007 mem_rdata  input  32;  mem_ack  input  1  memory read data and completion strobe.
REQ-008 mem_req, mem_we  output  1 each;  mem_addr, mem_wdata  output  32 each  memory request port.
REQ-009 pc, instr, mdr  output  32 each;  op, funct  output  6 each  (instr[31:26], instr[5:0]).
REQ-010 stall  output  1  freezes controller state advance while high;  err  output  1  sticky timeout flag.

Function
REQ-011 Access request (areq) SHALL be IRwrite | memread | memwrite; kind = fetch if IRwrite, else write if memwrite, else read.
REQ-012 FSM states SHALL be IDLE and BUSY only.
REQ-013 IDLE with areq: latch addr = IorD ? aluout : pc, wdata = writedata, kind; go BUSY next edge.
REQ-014 BUSY: mem_req = 1, mem_we = (kind==write), mem_addr/mem_wdata from latches, stable until ack.
REQ-015 mem_req and mem_we SHALL be 0 in IDLE; mem_ack in IDLE SHALL be ignored.
REQ-016 stall = (IDLE & areq) | (BUSY & !mem_ack); minimum access = 2 cycles (request cycle + ack cycle).
REQ-017 BUSY with mem_ack: fetch loads instr <= mem_rdata, read loads mdr <= mem_rdata, write loads nothing; next state IDLE.
REQ-018 PC SHALL update only when pcEn & !stall; jump target = {pc[31:28], instr[25:0], 2'b00}; pcsrc 11 holds.
REQ-019 A new areq in the IDLE cycle right after ack SHALL start a new access (back-to-back allowed).
REQ-020 Watchdog: 8-bit counter cleared on entry to BUSY, increments each BUSY cycle without ack; at 255 set err, return to IDLE, deassert stall, leave instr/mdr unchanged.
REQ-021 err SHALL clear only on reset.
REQ-022 Simultaneous IRwrite and memwrite SHALL be treated as fetch (fetch priority).

Reset
REQ-023 reset SHALL force immediately: state IDLE, pc = 0, instr = 0, mdr = 0, latches = 0, counter = 0, err = 0, mem_req = 0, mem_we = 0.
REQ-024 Reset mid-access SHALL abandon the access; a late mem_ack after reset release is ignored (IDLE).
REQ-025 stall after reset SHALL follow REQ-016 combinationally from the inputs.

Verification
REQ-026 Fetch: pc=0, IRwrite=1, pcEn=1, pcsrc=00, aluresult=4, mem_rdata=0x8C010004, ack on 1st BUSY cycle -> stall 1 then 0, instr=0x8C010004, op=0x23, pc=4.
REQ-027 Wait states: read IorD=1, aluout=0x40, ack after 3 BUSY cycles -> mem_addr=0x40 throughout, stall high 4 cycles, mdr loaded, pc unchanged.
REQ-028 Write: memwrite=1, aluout=0x80, writedata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, mdr/instr unchanged after ack.
REQ-029 Jump: pc=0x40000010, instr=0x08000003, pcEn=1, pcsrc=10, no areq -> pc=0x4000000C next edge, stall=0.
REQ-030 Timeout: read with no ack -> err=1 after 255 BUSY cycles, state IDLE, stall 0; err persists until reset.
REQ-031 Reset in BUSY with ack one cycle after release -> mem_req=0 immediately, instr/mdr=0, ack ignored.
